// File: rtl/prbs8_checker_if.sv
// -----------------------------------------------------------------------------
// prbs8_checker_if
//
// Bundles the sample/control inputs and status outputs of prbs8_checker so the
// checker and whatever drives it share a single connection.
//
//   en         master -> slave   bit-sample enable
//   d_in       master -> slave   received serial bit
//   clr_err    master -> slave   synchronous clear of the error counter
//   locked     slave  -> master  high while the checker is locked
//   err_pulse  slave  -> master  one-cycle pulse per detected bit error
//   err_count  slave  -> master  saturating error count (ERR_W bits)
//   state      slave  -> master  00 = FILL, 01 = HUNT, 10 = LOCKED
// -----------------------------------------------------------------------------
interface prbs8_checker_if #(
    parameter int ERR_W = 8
);
    logic             en;
    logic             d_in;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state;

    modport master (
        output en,
        output d_in,
        output clr_err,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  state
    );

    modport slave (
        input  en,
        input  d_in,
        input  clr_err,
        output locked,
        output err_pulse,
        output err_count,
        output state
    );
endinterface

// File: rtl/prbs8_checker.sv
// -----------------------------------------------------------------------------
// prbs8_checker
//
// Receive-side checker for the PRBS8 stream (x^8 + x^6 + x^5 + x^4 + 1) that
// comes back out of the SISO chain. It fills an 8-bit history register from
// the line, hunts for a run of correct predictions, then flywheels on its own
// predictor while counting line errors. Too many closely spaced errors drop
// it back to FILL so it can resynchronise.
//
// Ports:
//   i_clk     sampling clock (CLK_OUT)
//   i_rst_n   asynchronous active-low reset
//   bus       prbs8_checker_if slave modport (en, d_in, clr_err in;
//             locked, err_pulse, err_count, state out)
//
// state     | meaning
// ----------+------------------------------------------------------------------
// FILL  (00)| shifting line bits into the history register, no comparisons
// HUNT  (01)| self-synchronising; counting consecutive correct predictions
// LOCKED(10)| flywheel on predicted bits, flag/count errors, track strikes
// -----------------------------------------------------------------------------
module prbs8_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_ERR = 4,
    parameter int ERR_W    = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    prbs8_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'b00,
        ST_HUNT   = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int SW = $clog2(LOSS_ERR + 1);

    // Compare against "last value before terminal" so the transition happens
    // on the same edge the count would reach its target.
    localparam logic [MW-1:0] RUN_LAST    = MW'(LOCK_CNT - 1);
    localparam logic [SW-1:0] STRIKE_LAST = SW'(LOSS_ERR - 1);

    state_t           r_state;
    logic [7:0]       r_sr;
    logic [2:0]       r_fill_cnt;
    logic [MW-1:0]    r_match_cnt;
    logic [MW-1:0]    r_run_cnt;
    logic [SW-1:0]    r_strikes;
    logic             r_locked;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;

    logic             w_pred;
    logic             w_err;
    logic             w_err_hit;
    logic             w_cnt_sat;

    // r_sr[0] is the newest bit, r_sr[7] the oldest.
    assign w_pred    = r_sr[7] ^ r_sr[5] ^ r_sr[4] ^ r_sr[3];
    assign w_err     = bus.d_in ^ w_pred;
    // Errors only count when a bit is actually sampled while locked.
    assign w_err_hit = bus.en && (r_state == ST_LOCKED) && w_err;
    assign w_cnt_sat = &r_err_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_FILL;
            r_sr        <= 8'h00;
            r_fill_cnt  <= 3'd0;
            r_match_cnt <= '0;
            r_run_cnt   <= '0;
            r_strikes   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_err_hit;

            // The clear works regardless of EN; an error on the same edge
            // survives the clear as a count of one.
            if (bus.clr_err) begin
                r_err_count <= w_err_hit ? ERR_W'(1) : '0;
            end else if (w_err_hit && !w_cnt_sat) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end

            if (bus.en) begin
                case (r_state)
                    ST_FILL: begin
                        r_sr <= {r_sr[6:0], bus.d_in};
                        if (r_fill_cnt == 3'd7) begin
                            r_fill_cnt  <= 3'd0;
                            r_match_cnt <= '0;
                            r_state     <= ST_HUNT;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + 3'd1;
                        end
                    end

                    ST_HUNT: begin
                        r_sr <= {r_sr[6:0], bus.d_in};
                        // An all-zero history predicts zero forever, so a
                        // stuck-low line must never accumulate matches.
                        if ((r_sr == 8'h00) || w_err) begin
                            r_match_cnt <= '0;
                        end else if (r_match_cnt == RUN_LAST) begin
                            r_match_cnt <= '0;
                            r_run_cnt   <= '0;
                            r_strikes   <= '0;
                            r_locked    <= 1'b1;
                            r_state     <= ST_LOCKED;
                        end else begin
                            r_match_cnt <= r_match_cnt + MW'(1);
                        end
                    end

                    ST_LOCKED: begin
                        // Flywheel: feed back the prediction so a corrupted
                        // line bit cannot poison the predictor.
                        r_sr <= {r_sr[6:0], w_pred};
                        if (w_err) begin
                            r_run_cnt <= '0;
                            if (r_strikes == STRIKE_LAST) begin
                                r_strikes  <= '0;
                                r_fill_cnt <= 3'd0;
                                r_locked   <= 1'b0;
                                r_state    <= ST_FILL;
                            end else begin
                                r_strikes <= r_strikes + SW'(1);
                            end
                        end else if (r_run_cnt == RUN_LAST) begin
                            r_run_cnt <= '0;
                            r_strikes <= '0;
                        end else begin
                            r_run_cnt <= r_run_cnt + MW'(1);
                        end
                    end

                    default: begin
                        r_locked <= 1'b0;
                        r_state  <= ST_FILL;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
    assign bus.state     = r_state;

endmodule
